// File: rtl/aes_round_sequencer.sv
// AES round sequencer: owns the 4x4 byte state, walks it through the
// initial AddRoundKey, NR-1 full rounds and the final round. Round keys
// arrive over a req/valid handshake; SubBytes/ShiftRows/MixColumns live
// outside and are reached through the rf_* ports.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; ct_out/ct_valid hold the last result
// WAIT_KEY | key_req high, one AddRoundKey per key handshake
// DONE     | one-cycle completion pulse, result marked valid on exit
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [0:3][0:3][7:0]    pt_in,
  input  logic                    abort,
  output logic                    ready,
  output logic                    busy,
  output logic                    key_req,
  output logic [RW-1:0]           key_round,
  input  logic                    key_valid,
  input  logic [0:3][0:3][7:0]    key_in,
  output logic [0:3][0:3][7:0]    rf_state,
  output logic                    rf_final,
  input  logic [0:3][0:3][7:0]    rf_result,
  output logic [0:3][0:3][7:0]    ct_out,
  output logic                    ct_valid,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam logic [RW-1:0] LP_NR = RW'(NR);

  state_e                 r_fsm;
  state_e                 w_fsm_nxt;
  logic [RW-1:0]          r_round;
  logic [RW-1:0]          w_round_nxt;
  logic [0:3][0:3][7:0]   r_data;
  logic [0:3][0:3][7:0]   w_data_nxt;
  logic                   r_ct_valid;
  logic                   w_ct_valid_nxt;

  logic                   w_last_round;
  logic [0:3][0:3][7:0]   w_ark_src;
  logic [0:3][0:3][7:0]   w_ark;

  assign w_last_round = (r_round == LP_NR);

  // Round 0 is the bare key addition; later rounds add the key to the round-function output.
  always_comb begin
    w_ark_src = (r_round == '0) ? r_data : rf_result;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_ark[r][c] = w_ark_src[r][c] ^ key_in[r][c];
      end
    end
  end

  // State register, round counter and result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_round    <= '0;
      r_data     <= '0;
      r_ct_valid <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_round    <= w_round_nxt;
      r_data     <= w_data_nxt;
      r_ct_valid <= w_ct_valid_nxt;
    end
  end

  // Next-state logic; abort wins over a same-cycle key handshake and
  // leaves the data register untouched.
  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_round_nxt    = r_round;
    w_data_nxt     = r_data;
    w_ct_valid_nxt = r_ct_valid;
    case (r_fsm)
      IDLE: begin
        if (start && !abort) begin
          w_data_nxt     = pt_in;
          w_round_nxt    = '0;
          w_ct_valid_nxt = 1'b0;
          w_fsm_nxt      = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (abort) begin
          w_fsm_nxt      = IDLE;
          w_round_nxt    = '0;
          w_ct_valid_nxt = 1'b0;
        end else if (key_valid) begin
          w_data_nxt = w_ark;
          if (w_last_round) begin
            w_fsm_nxt = DONE;
          end else begin
            w_round_nxt = r_round + 1'b1;
          end
        end
      end
      DONE: begin
        w_fsm_nxt   = IDLE;
        w_round_nxt = '0;
        if (abort) begin
          w_ct_valid_nxt = 1'b0;
        end else begin
          w_ct_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_fsm_nxt      = IDLE;
        w_round_nxt    = '0;
        w_ct_valid_nxt = 1'b0;
      end
    endcase
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    ready     = (r_fsm == IDLE);
    busy      = (r_fsm == WAIT_KEY) || (r_fsm == DONE);
    key_req   = (r_fsm == WAIT_KEY);
    key_round = r_round;
    rf_final  = (r_fsm == WAIT_KEY) && w_last_round;
    done      = (r_fsm == DONE) && !abort;
    rf_state  = r_data;
    ct_out    = r_data;
    ct_valid  = r_ct_valid;
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: directed blocks with a scoreboard queue of
// expected ciphertexts, popped by a monitor on every done pulse.
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam int RW = 4;

  typedef logic [0:3][0:3][7:0] state_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          key_valid = 1'b0;
  state_t        pt_in = '0;
  state_t        key_in;
  state_t        rf_result;
  state_t        rf_state;
  state_t        ct_out;
  logic          ready, busy, key_req, rf_final, ct_valid, done;
  logic [RW-1:0] key_round;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     start_cyc = 0;
  int     done_cnt = 0;
  bit     rf_mode = 1'b0;
  state_t exp_q[$];
  int     hs_log[$];
  state_t rk[0:NR];
  logic [31:0] w[0:4*(NR+1)-1];

  logic [0:255][7:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_round_sequencer #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pt_in(pt_in), .abort(abort),
    .ready(ready), .busy(busy), .key_req(key_req), .key_round(key_round),
    .key_valid(key_valid), .key_in(key_in), .rf_state(rf_state),
    .rf_final(rf_final), .rf_result(rf_result), .ct_out(ct_out),
    .ct_valid(ct_valid), .done(done));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t fill(input logic [7:0] b);
    state_t s;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = b;
    return s;
  endfunction

  // FIPS-197 byte stream order: byte i goes to row i%4, column i/4.
  function automatic state_t from_bytes(input logic [127:0] v);
    state_t s;
    for (int i = 0; i < 16; i++) s[i%4][i/4] = v[127-8*i -: 8];
    return s;
  endfunction

  function automatic state_t aes_rf(input state_t s, input logic fin);
    state_t t, m;
    logic [7:0] a0, a1, a2, a3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = sbox_tbl[s[r][(c+r)%4]];
    if (fin) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
      m[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      m[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      m[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      m[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return m;
  endfunction

  // Environment: key schedule source and round function.
  always_comb begin
    if (rf_mode) key_in = (int'(key_round) <= NR) ? rk[key_round] : '0;
    else         key_in = fill({4'h0, key_round});
  end

  always_comb begin
    rf_result = rf_mode ? aes_rf(rf_state, rf_final) : rf_state;
  end

  task automatic chk(input string nm, input state_t act, input state_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: logs key handshakes and scores every done pulse against the queue.
  always @(negedge clk) begin
    state_t e;
    if (rst_n && key_req && key_valid && !abort) begin
      hs_log.push_back(int'(key_round));
      chk_i("rf_final_at_handshake", int'(rf_final), int'(key_round == RW'(NR)));
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk_i("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ct_out_at_done", ct_out, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input state_t p, input bit push, input state_t e);
    pt_in = p;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    hs_log.delete();
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_round(input int r);
    int g = 0;
    while (int'(key_round) != r && g < 50) begin
      tick();
      g++;
    end
    chk_i("reach_key_round", int'(key_round), r);
  endtask

  task automatic wait_done(input int exp_lat);
    int g = 0;
    while (!done && g < 200) begin
      tick();
      g++;
    end
    chk_i("done_latency", cyc - start_cyc, exp_lat);
    chk_i("rf_final_in_done", int'(rf_final), 0);
    tick();
    chk_i("ready_after_done", int'(ready), 1);
    chk_i("ct_valid_after_done", int'(ct_valid), 1);
  endtask

  task automatic check_hs();
    chk_i("handshake_count", hs_log.size(), NR + 1);
    for (int i = 0; i < hs_log.size() && i <= NR; i++) chk_i("handshake_round", hs_log[i], i);
  endtask

  task automatic chk_reset_vals();
    chk_i("rst_ready", int'(ready), 1);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_key_req", int'(key_req), 0);
    chk_i("rst_key_round", int'(key_round), 0);
    chk_i("rst_rf_final", int'(rf_final), 0);
    chk_i("rst_ct_valid", int'(ct_valid), 0);
    chk_i("rst_done", int'(done), 0);
    chk("rst_ct_out", ct_out, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t p_a, q_a, z;
    logic [31:0] temp;
    logic [7:0]  rc;

    // Reference AES-128 key schedule for key 000102..0f.
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rc = 8'h01;
    for (int i = 4; i < 4*(NR+1); i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_tbl[temp[31:24]], sbox_tbl[temp[23:16]],
                sbox_tbl[temp[15:8]], sbox_tbl[temp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NR; r++)
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          rk[r][row][col] = w[4*r+col][31-8*row -: 8];

    z   = '0;
    p_a = from_bytes(128'h0123456789abcdeffedcba9876543210);
    q_a = from_bytes(128'h00112233445566778899aabbccddeeff);

    // Reset values.
    tick();
    tick();
    chk_reset_vals();
    rst_n = 1'b1;
    key_valid = 1'b1;
    tick();

    // Identity round function, zero plaintext: XOR of 0..10 per byte = 0x0b.
    issue(z, 1'b1, fill(8'h0b));
    wait_done(NR + 1);
    check_hs();

    // Reference AES-128 (FIPS-197 C.1).
    rf_mode = 1'b1;
    issue(q_a, 1'b1, from_bytes(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    wait_done(NR + 1);
    check_hs();
    rf_mode = 1'b0;

    // Three-cycle key stall at round 5: state holds 0^0^1^2^3^4 = 0x04.
    issue(z, 1'b1, fill(8'h0b));
    wait_round(5);
    key_valid = 1'b0;
    repeat (3) begin
      tick();
      chk_i("stall_key_round", int'(key_round), 5);
      chk("stall_state", ct_out, fill(8'h04));
    end
    key_valid = 1'b1;
    wait_done(NR + 4);
    check_hs();

    // Start while busy is ignored; a start after done is accepted.
    issue(p_a, 1'b1, from_bytes(128'h0a284e6c82a0c6e4f5d7b1937d5f391b));
    wait_round(3);
    pt_in = q_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_i("busy_after_ignored_start", int'(busy), 1);
    wait_done(NR + 1);
    check_hs();
    issue(q_a, 1'b1, from_bytes(128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4));
    chk_i("ct_valid_drop_on_accept", int'(ct_valid), 0);
    wait_done(NR + 1);

    // Abort at round 4 with key_valid high: P^0^1^2^3 = P, handshake 4 not applied.
    issue(p_a, 1'b0, z);
    wait_round(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_i("abort_ready", int'(ready), 1);
    chk_i("abort_busy", int'(busy), 0);
    chk_i("abort_ct_valid", int'(ct_valid), 0);
    chk_i("abort_key_round", int'(key_round), 0);
    chk("abort_no_handshake", ct_out, p_a);
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) tick();
      chk_i("abort_no_done", done_cnt, d0);
    end

    // Abort in the DONE cycle suppresses the pulse and the valid flag.
    issue(z, 1'b0, z);
    wait_round(NR);
    tick();
    abort = 1'b1;
    #1;
    chk_i("abort_in_done_pulse", int'(done), 0);
    tick();
    abort = 1'b0;
    chk_i("abort_in_done_ready", int'(ready), 1);
    chk_i("abort_in_done_ct_valid", int'(ct_valid), 0);

    // start together with abort in IDLE is ignored.
    pt_in = q_a;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_i("start_abort_idle_ready", int'(ready), 1);
    chk_i("start_abort_idle_busy", int'(busy), 0);

    // Asynchronous reset at round 7, then a normal block.
    issue(z, 1'b0, z);
    wait_round(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    issue(q_a, 1'b1, from_bytes(128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4));
    wait_done(NR + 1);
    check_hs();

    tick();
    chk_i("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES encryption controller that owns the 4x4 byte state register and sequences it through the initial AddRoundKey, NR-1 full rounds and one final round. Round keys are pulled from the key-schedule block over a req/valid handshake. The combinational round function (SubBytes/ShiftRows/MixColumns) is external and is reached through rf_* ports. The AddRoundKey XOR is performed inside this block.

Parameters:
NR, 10, total number of rounds after the initial key addition (10/12/14 for AES-128/192/256)
RW, 4, width of the round counter and key_round; must satisfy 2**RW > NR

Ports:
clk  input  1  clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new block; accepted only when ready=1
pt_in  input  [7:0] [0:3][0:3]  plaintext block, [row][col] bytes, sampled when start is accepted
abort  input  1  synchronous cancel of the current operation
ready  output  1  high in IDLE only
busy  output  1  high in WAIT_KEY and DONE
key_req  output  1  round-key request, high throughout WAIT_KEY
key_round  output  RW  index of the requested round key, 0..NR
key_valid  input  1  key_in is valid; the handshake fires on key_req & key_valid
key_in  input  [7:0] [0:3][0:3]  round key for key_round
rf_state  output  [7:0] [0:3][0:3]  current state register, driven to the round function
rf_final  output  1  high when key_round==NR; the round function must skip MixColumns
rf_result  input  [7:0] [0:3][0:3]  round-function output (combinational from rf_state/rf_final)
ct_out  output  [7:0] [0:3][0:3]  ciphertext, equals the state register
ct_valid  output  1  ct_out holds a completed result
done  output  1  single-cycle completion pulse

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; round counter=0; state register=0.
  - Outputs: ready=1, busy=0, key_req=0, key_round=0, rf_final=0, ct_valid=0, done=0, ct_out=0.
- FSM states: IDLE, WAIT_KEY, DONE.
- IDLE:
  - start=1 loads pt_in into the state register, sets round=0 and ct_valid=0, then moves to WAIT_KEY.
  - start=0 holds; ct_out and ct_valid are held.
- WAIT_KEY: key_req=1, key_round=round.
  - Handshake with round=0: state <= state ^ key_in.
  - Handshake with round 1..NR: state <= rf_result ^ key_in.
  - After a handshake: if round==NR, go to DONE; otherwise round increments and the FSM stays in WAIT_KEY.
  - No handshake (key_valid=0): state, round and key_round are all held, with no limit on stall length.
- DONE: done=1 for exactly one cycle, ct_valid set to 1, then go to IDLE.
- Latency: with key_valid tied high, start is sampled at edge k, handshakes occur at edges k+1..k+NR+1, done is high in the cycle following edge k+NR+1, and ready returns one cycle later. Each stall cycle adds one cycle.
- start while busy is ignored, with no queuing.
- abort=1 in WAIT_KEY or DONE: go to IDLE next edge, round=0, ct_valid=0, no done pulse. The state register is left undefined-but-stable (not cleared).
- abort has priority over a same-cycle handshake. abort in IDLE has no effect, and start plus abort in IDLE are ignored together.
- Byte mapping is [row][col]; the XOR is bytewise, with no carries.
- rf_final is derived combinationally from key_round==NR and is 0 outside WAIT_KEY.
- Reset mid-operation aborts immediately; no done pulse is produced.

Test Plan:
- Identity round function (rf_result=rf_state), key_in = every byte equal to key_round, key_valid=1, pt_in all 0x00 → exactly 11 handshakes, key_round sequence 0..10, rf_final high only at round 10, ct_out all 0x0B, done one cycle at start+12, ready at start+13.
- Reference round function and key schedule, key 000102..0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, ct_valid=1.
- Identity setup with key_valid low for 3 cycles at key_round=5 → state and key_round held at 5, done at start+15, ct_out all 0x0B.
- start pulsed at key_round=3 of a running op → ignored; result unchanged; a second start after done is accepted and ct_valid drops the cycle after acceptance.
- abort at key_round=4 → ready next cycle, ct_valid=0, no done pulse; abort coincident with key_valid → handshake not applied.
- rst_n low at key_round=7 → all outputs at reset values immediately; after release, a new block completes normally.
